axis_frame_arbiter: RTL and testbench
=====================================

Name: axis_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that merges S_COUNT AXI4-Stream sources into one stream, typically feeding the shared axis_fifo instance.
- Grants one source per frame and holds the grant until that source's tlast beat transfers.
- Tags every output beat with the source index on m_axis_tid so downstream logic can demultiplex.
- Output is a single registered stage, with no combinational path from m_axis_tready to m_axis_tvalid or m_axis_tdata.

Parameters:
S_COUNT, 4, number of input streams (2..16)
DATA_WIDTH, 8, tdata width in bits
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
USER_WIDTH, 1, tuser width
ID_WIDTH, $clog2(S_COUNT), m_axis_tid width (localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  S_COUNT*DATA_WIDTH  packed input data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  input  S_COUNT*KEEP_WIDTH  packed tkeep
s_axis_tvalid  input  S_COUNT  per-source valid
s_axis_tready  output  S_COUNT  per-source ready
s_axis_tlast  input  S_COUNT  per-source end of frame
s_axis_tuser  input  S_COUNT*USER_WIDTH  packed tuser
m_axis_tdata  output  DATA_WIDTH  merged data
m_axis_tkeep  output  KEEP_WIDTH  merged tkeep
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  end of frame
m_axis_tid  output  ID_WIDTH  index of the source of the current beat
m_axis_tuser  output  USER_WIDTH  merged tuser
grant  output  S_COUNT  one-hot current grant; all zero in IDLE
busy  output  1  high in ACTIVE state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, grant=0, busy=0, s_axis_tready=0.
  - m_axis_tvalid=0; m_axis_tdata, tkeep, tlast, tid and tuser all 0.
  - last_grant_idx=S_COUNT-1, so source 0 has top priority after reset.
  - Deassertion is used as-is; there is no internal synchronizer.
- FSM:
  - IDLE: if any s_axis_tvalid is high, select the first requesting index scanning upward from last_grant_idx+1, wrapping modulo S_COUNT. Register grant and last_grant_idx, then go to ACTIVE. With no request, stay in IDLE. All s_axis_tready are 0 in IDLE.
  - ACTIVE: s_axis_tready[g] = !m_axis_tvalid || m_axis_tready for the granted index g. All other tready bits are 0, so at most one tready bit is ever high.
  - A granted beat that transfers (tvalid && tready) loads the output register on the same edge, with m_axis_tid=g.
  - When the transferring beat has s_axis_tlast=1, go to IDLE on that edge and clear grant.
- Output register: cleared to m_axis_tvalid=0 when m_axis_tready=1 and no new beat loads; held when m_axis_tvalid=1 and m_axis_tready=0.
- Latency:
  - Request in IDLE at cycle 0 -> grant valid in cycle 1 -> first beat captured at end of cycle 1 -> m_axis_tvalid in cycle 2.
  - Back-to-back frames: tlast captured at cycle k, IDLE at k+1, ACTIVE at k+2. This is exactly one dead input cycle between frames.
  - Within a frame, throughput is 1 beat/cycle while m_axis_tready=1.
- Boundary conditions:
  - Granted source drops tvalid mid-frame: grant is held indefinitely and no other source is served. There is no timeout.
  - Single-beat frame (tlast on the first beat): ACTIVE lasts exactly one transfer.
  - A source deasserting tvalid while in IDLE before being granted simply loses that arbitration round.
  - Only the requesting source: re-granted every frame, with the one-cycle gap.
  - Round-robin pointer wraps from S_COUNT-1 to 0.
  - Reset mid-frame: frame truncated, and the output register is discarded even if valid. The upstream source is expected to restart.
  - Beat order and contents (data, keep, last, user) are passed through unmodified.

Test Plan:
- Reset then sources 0..3 all valid, each sending 3-beat frames, m_axis_tready=1 -> output tid sequence 0,0,0,1,1,1,2,2,2,3,3,3,0..., one idle input cycle between frames, first m_axis_tvalid 2 cycles after tvalid.
- Source 2 sends frame 0xA0,0xA1,0xA2 while source 1 raises tvalid mid-frame -> all three beats carry tid=2 with no interleave; source 1 is granted next.
- Hold m_axis_tready=0 for 5 cycles mid-frame -> m_axis_tdata stable, m_axis_tvalid stays 1, s_axis_tready[g]=0; resume gives no lost or duplicated beats.
- Single-beat frames (tlast=1) from sources 1 and 3 only -> grant alternates 1,3,1,3; grant one-hot in ACTIVE, 0 in IDLE.
- Assert rst_n=0 asynchronously after the second beat of a 4-beat frame from source 0 -> m_axis_tvalid and all s_axis_tready drop immediately; after release, source 0 wins again if requesting.
- Granted source 1 drops tvalid for 10 cycles mid-frame while source 0 requests -> no grant change, busy=1, frame completes after tvalid returns.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-granular round-robin merge of S_COUNT AXI4-Stream sources
// into one registered output stream tagged with the source index.
module axis_frame_arbiter #(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = (DATA_WIDTH/8),
   parameter int USER_WIDTH = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   output logic [S_COUNT-1:0]            s_axis_tready,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [$clog2(S_COUNT)-1:0]    m_axis_tid,
   output logic [USER_WIDTH-1:0]         m_axis_tuser,
   output logic [S_COUNT-1:0]            grant,
   output logic                          busy
);
   localparam int ID_WIDTH = $clog2(S_COUNT);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] last_idx;
   logic [ID_WIDTH-1:0] sel;
   logic [ID_WIDTH-1:0] idx;
   logic                found;
   logic                take;
   logic                xfer;

   // First requester strictly after the previous winner, wrapping modulo S_COUNT
   always_comb begin
      sel   = last_idx;
      idx   = last_idx;
      found = 1'b0;
      for (int k = 1; k <= S_COUNT; k++) begin
         idx = ID_WIDTH'((int'(last_idx) + k) % S_COUNT);
         if (!found && s_axis_tvalid[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   // grant is zero outside ACTIVE, so it doubles as the tready enable mask
   assign take          = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = grant & {S_COUNT{take}};
   assign xfer          = |(s_axis_tvalid & s_axis_tready);
   assign busy          = (state == ACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         last_idx      <= ID_WIDTH'(S_COUNT - 1);
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tid    <= '0;
         m_axis_tuser  <= '0;
      end else begin
         if (xfer) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata[last_idx*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep  <= s_axis_tkeep[last_idx*KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tlast  <= s_axis_tlast[last_idx];
            m_axis_tuser  <= s_axis_tuser[last_idx*USER_WIDTH +: USER_WIDTH];
            m_axis_tid    <= last_idx;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (state == IDLE) begin
            if (found) begin
               state    <= ACTIVE;
               grant    <= {{(S_COUNT-1){1'b0}}, 1'b1} << sel;
               last_idx <= sel;
            end
         end else if (xfer && s_axis_tlast[last_idx]) begin
            state <= IDLE;
            grant <= '0;
         end
      end
   end
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter: directed frames per source, scoreboard of expected output beats
// checked by an independent monitor, plus inline checks of grant/latency/stall/reset.
module tb_axis_frame_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0]  m_tdata;
   logic        m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser;
   logic [1:0]  m_tid;
   logic [3:0]  grant;
   logic        busy;

   always #5 clk = ~clk;

   axis_frame_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
      .m_axis_tuser(m_tuser), .grant(grant), .busy(busy)
   );

   typedef struct packed {logic [1:0] id; logic [7:0] d; logic l;} beat_t;

   logic [7:0] mem_d [4][64];
   logic       mem_l [4][64];
   int         slen [4];
   int         ptr [4];
   logic [3:0] hold, hs;
   logic       flush;
   beat_t      exp_q [$];
   int         checks, failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Queue a frame on source s; the first nexp beats are expected at the output in call order
   task automatic add_frame(input int s, input logic [7:0] base, input int n, input int nexp);
      for (int j = 0; j < n; j++) begin
         mem_d[s][slen[s]] = base + 8'(j);
         mem_l[s][slen[s]] = (j == n - 1);
         if (j < nexp) exp_q.push_back('{id: 2'(s), d: base + 8'(j), l: (j == n - 1)});
         slen[s]++;
      end
   endtask

   task automatic wait_empty(input int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         @(negedge clk);
         #4;
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   // Source drivers: advance on the handshake seen just before the last rising edge
   initial begin
      foreach (ptr[i]) ptr[i] = 0;
      s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0; s_tkeep = 4'hF;
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            ptr[i] = flush ? slen[i] : ptr[i] + int'(hs[i]);
            s_tvalid[i] = (ptr[i] < slen[i]) && !hold[i];
            s_tdata[i*8 +: 8] = (ptr[i] < slen[i]) ? mem_d[i][ptr[i]] : 8'h00;
            s_tlast[i] = (ptr[i] < slen[i]) ? mem_l[i][ptr[i]] : 1'b0;
            s_tuser[i] = s_tdata[i*8];
         end
      end
   end

   // Monitor: every output beat must match the head of the scoreboard
   initial begin
      beat_t e;
      hs = '0;
      forever begin
         @(negedge clk);
         #3;
         for (int i = 0; i < 4; i++) hs[i] = rst_n && s_tvalid[i] && s_tready[i];
         if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual tid=%0d data=%h required none", m_tid, m_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat", {19'd0, m_tid, m_tdata, m_tlast, m_tuser, m_tkeep},
                   {19'd0, e.id, e.d, e.l, e.d[0], 1'b1});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n, b;
      m_tready = 1'b1;
      hold = '0;
      flush = 1'b0;
      #3;
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_sready", s_tready, 0);
      chk("rst_mdata", m_tdata, 0);
      chk("rst_mtid", m_tid, 0);
      chk("rst_mlast", m_tlast, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // All sources, two 3-beat frames each: tid order 0,1,2,3,0,1,2,3
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < 4; s++) add_frame(s, 8'(s*16 + f*4), 3, 3);
      @(posedge clk); #2;
      chk("t1_grant0", grant, 4'b0001);
      chk("t1_busy", busy, 1);
      chk("t1_mvalid_lat1", m_tvalid, 0);
      @(posedge clk); #2;
      chk("t1_mvalid_lat2", m_tvalid, 1);
      chk("t1_first_data", m_tdata, 8'h00);
      repeat (3) @(posedge clk);
      #2;
      chk("t1_gap_mvalid", m_tvalid, 0);
      chk("t1_grant1", grant, 4'b0010);
      wait_empty(400);

      // Source 1 requests while source 2 is mid-frame
      add_frame(2, 8'hA0, 3, 3);
      repeat (3) @(negedge clk);
      add_frame(1, 8'hB0, 2, 2);
      #2;
      chk("t2_grant2", grant, 4'b0100);
      wait_empty(100);

      // Output stall for 5 cycles mid-frame
      add_frame(0, 8'hC0, 4, 4);
      n = 0;
      do begin @(negedge clk); #2; n++; end while (!m_tvalid && n < 50);
      chk("t3_first_valid", m_tvalid, 1);
      @(negedge clk);
      m_tready = 1'b0;
      repeat (5) begin
         #2;
         chk("t3_hold_data", m_tdata, 8'hC1);
         chk("t3_hold_valid", m_tvalid, 1);
         chk("t3_sready", s_tready, 0);
         @(negedge clk);
      end
      m_tready = 1'b1;
      wait_empty(100);

      // Single-beat frames from sources 1 and 3 alternate
      add_frame(1, 8'h11, 1, 1);
      add_frame(3, 8'h31, 1, 1);
      add_frame(1, 8'h12, 1, 1);
      add_frame(3, 8'h32, 1, 1);
      repeat (14) begin
         @(posedge clk); #2;
         chk("t4_onehot", busy ? $onehot(grant) : (grant == 4'b0000), 1);
      end
      wait_empty(100);

      // Granted source 1 stalls mid-frame for 10 cycles while source 0 waits
      b = slen[1];
      add_frame(1, 8'hE0, 4, 4);
      n = 0;
      do begin @(negedge clk); n++; end while (ptr[1] < b + 2 && n < 50);
      hold[1] = 1'b1;
      add_frame(0, 8'hF0, 2, 2);
      repeat (10) begin
         @(posedge clk); #2;
         chk("t6_grant_held", grant, 4'b0010);
         chk("t6_busy", busy, 1);
      end
      @(negedge clk);
      hold[1] = 1'b0;
      wait_empty(100);

      // Asynchronous reset after two beats of a 4-beat frame: remainder is discarded
      b = slen[0];
      add_frame(0, 8'h70, 4, 2);
      n = 0;
      do begin @(negedge clk); n++; end while (ptr[0] < b + 2 && n < 50);
      rst_n = 1'b0;
      #2;
      chk("t5_mvalid", m_tvalid, 0);
      chk("t5_sready", s_tready, 0);
      chk("t5_busy", busy, 0);
      chk("t5_grant", grant, 0);
      flush = 1'b1;
      @(negedge clk); #2;
      flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      add_frame(0, 8'h50, 2, 2);
      add_frame(2, 8'h60, 1, 1);
      @(posedge clk); #2;
      chk("t5_regrant0", grant, 4'b0001);
      wait_empty(100);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
